// File: rtl/vga_vram_pkg.sv
// vga_vram_pkg: shared VRAM port widths, host-read FSM states and port grant encoding.
package vga_vram_pkg;
    localparam int DEFAULT_ADDR_W = 13;
    localparam int DEFAULT_DATA_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_DATA = 2'd2} rdState_t;
    typedef enum logic [1:0] {NONE, DISP, HWR, HRD} grant_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: posted host-write FIFO; pushes while full are dropped, pops while empty ignored.
module vram_wr_fifo #(
    parameter int W = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0] count, countNext;
    logic doPush, doPop;
    always_comb begin
        doPush = push && !full;
        doPop = pop && !empty;
        countNext = count + (PW+1)'(doPush) - (PW+1)'(doPop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= countNext;
            full <= countNext == (PW+1)'(DEPTH);
        end
    end
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end
    assign empty = count == '0;
    assign head = mem[rdPtr];
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between display fetch (absolute priority),
// posted host writes and host reads serialized behind those writes.
module vram_arbiter
    import vga_vram_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic [DATA_W-1:0] dispData,
    output logic              dispValid,
    input  logic              hostWr,
    input  logic [ADDR_W-1:0] hostWrAddr,
    input  logic [DATA_W-1:0] hostWrData,
    output logic              hostWrFull,
    output logic              hostWrOvf,
    input  logic              hostRdReq,
    input  logic [ADDR_W-1:0] hostRdAddr,
    output logic [DATA_W-1:0] hostRdData,
    output logic              hostRdValid,
    output logic              hostRdBusy,
    output logic              vramEn,
    output logic              vramWe,
    output logic [ADDR_W-1:0] vramAddr,
    output logic [DATA_W-1:0] vramWrData,
    input  logic [DATA_W-1:0] vramRdData
);
    logic prevWr, prevRd, wrEdge, rdEdge, fifoEmpty;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0] rdAddr;
    rdState_t state;
    grant_t grant;

    assign wrEdge = hostWr && !prevWr;
    assign rdEdge = hostRdReq && !prevRd;
    // The read only wins once the FIFO is drained, so it sees every earlier write
    assign grant = dispReq ? DISP : !fifoEmpty ? HWR : (state == RD_WAIT) ? HRD : NONE;

    vram_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(WFIFO_DEPTH)) wrFifo (
        .clk(clk),
        .rst(rst),
        .push(wrEdge),
        .pushData({hostWrAddr, hostWrData}),
        .pop(grant == HWR),
        .full(hostWrFull),
        .empty(fifoEmpty),
        .head(head)
    );

    always_comb begin
        vramEn = !rst && grant != NONE;
        vramWe = !rst && grant == HWR;
        vramAddr = grant == DISP ? dispAddr : grant == HWR ? head[ADDR_W+DATA_W-1:DATA_W] : rdAddr;
        vramWrData = head[DATA_W-1:0];
    end

    assign dispData = vramRdData;
    assign hostRdBusy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevWr <= 1'b0;
            prevRd <= 1'b0;
            hostWrOvf <= 1'b0;
            hostRdData <= '0;
            hostRdValid <= 1'b0;
            dispValid <= 1'b0;
            rdAddr <= '0;
            state <= IDLE;
        end else begin
            prevWr <= hostWr;
            prevRd <= hostRdReq;
            dispValid <= dispReq;
            hostRdValid <= 1'b0;
            if (wrEdge && hostWrFull) hostWrOvf <= 1'b1;
            if (state == IDLE && rdEdge) begin
                state <= RD_WAIT;
                rdAddr <= hostRdAddr;
            end else if (grant == HRD) begin
                state <= RD_DATA;
            end else if (state == RD_DATA) begin
                state <= IDLE;
                hostRdData <= vramRdData;
                hostRdValid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized scoreboard bench; a queue-based model predicts port usage,
// flags and read data per cycle while a negedge monitor compares what the DUT shows.
module tb_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dispReq = 1'b0, hostWr = 1'b0, hostRdReq = 1'b0;
    logic [AW-1:0] dispAddr = '0, hostWrAddr = '0, hostRdAddr = '0;
    logic [DW-1:0] hostWrData = '0;
    logic [DW-1:0] dispData, hostRdData, vramWrData;
    logic [DW-1:0] vramRdData = '0;
    logic dispValid, hostWrFull, hostWrOvf, hostRdValid, hostRdBusy, vramEn, vramWe;
    logic [AW-1:0] vramAddr;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dispReq(dispReq), .dispAddr(dispAddr), .dispData(dispData), .dispValid(dispValid),
        .hostWr(hostWr), .hostWrAddr(hostWrAddr), .hostWrData(hostWrData),
        .hostWrFull(hostWrFull), .hostWrOvf(hostWrOvf),
        .hostRdReq(hostRdReq), .hostRdAddr(hostRdAddr), .hostRdData(hostRdData),
        .hostRdValid(hostRdValid), .hostRdBusy(hostRdBusy),
        .vramEn(vramEn), .vramWe(vramWe), .vramAddr(vramAddr), .vramWrData(vramWrData),
        .vramRdData(vramRdData)
    );

    // VRAM device: synchronous single port, read data one cycle after the access
    logic [DW-1:0] vmem [1<<AW];
    always @(posedge clk) begin
        if (vramEn && vramWe) vmem[vramAddr] <= vramWrData;
        if (vramEn && !vramWe) vramRdData <= vmem[vramAddr];
    end

    typedef struct packed {bit en; bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} port_t;
    typedef struct packed {bit full; bit ovf; bit busy; bit dv; bit rv;} flag_t;
    port_t portQ[$];
    flag_t flagQ[$];
    logic [DW-1:0] dispQ[$];
    logic [DW-1:0] rdQ[$];

    logic [AW+DW-1:0] mFifo[$];
    logic [DW-1:0] mMem [1<<AW];
    bit mPrevWr, mPrevRd, mPrevDisp, mOvf, mRdWait;
    int mGrantCyc, cyc;
    logic [AW-1:0] mRdAddr;
    int checks = 0, errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mFifo.delete();
        portQ.delete();
        flagQ.delete();
        dispQ.delete();
        rdQ.delete();
        mPrevWr = 0;
        mPrevRd = 0;
        mPrevDisp = 0;
        mOvf = 0;
        mRdWait = 0;
        mGrantCyc = -100;
        cyc = 0;
    endtask

    // Drive one cycle's inputs and predict everything the DUT should show this cycle
    task automatic step(bit d, logic [AW-1:0] da, bit w, logic [AW-1:0] wa, logic [DW-1:0] wd,
                        bit r, logic [AW-1:0] ra);
        port_t p;
        flag_t f;
        int startCnt;
        logic [AW+DW-1:0] e;
        dispReq = d; dispAddr = da;
        hostWr = w; hostWrAddr = wa; hostWrData = wd;
        hostRdReq = r; hostRdAddr = ra;
        startCnt = mFifo.size();
        f.full = startCnt == DEPTH;
        f.ovf = mOvf;
        f.busy = mRdWait || cyc == mGrantCyc + 1;
        f.dv = mPrevDisp;
        f.rv = cyc == mGrantCyc + 2;
        p = '0;
        if (d) begin
            p.en = 1; p.addr = da;
            dispQ.push_back(mMem[da]);
        end else if (startCnt > 0) begin
            e = mFifo.pop_front();
            p.en = 1; p.we = 1; p.addr = e[AW+DW-1:DW]; p.data = e[DW-1:0];
            mMem[p.addr] = p.data;
        end else if (mRdWait) begin
            p.en = 1; p.addr = mRdAddr;
            rdQ.push_back(mMem[mRdAddr]);
            mGrantCyc = cyc;
            mRdWait = 0;
        end
        if (w && !mPrevWr) begin
            if (startCnt == DEPTH) mOvf = 1;
            else mFifo.push_back({wa, wd});
        end
        if (r && !mPrevRd && !f.busy) begin
            mRdWait = 1;
            mRdAddr = ra;
        end
        mPrevWr = w; mPrevRd = r; mPrevDisp = d;
        portQ.push_back(p);
        flagQ.push_back(f);
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            tick();
            step(0, '0, 0, '0, '0, 0, '0);
        end
    endtask

    task automatic doReset();
        rst = 1;
        dispReq = 0; hostWr = 0; hostRdReq = 0;
        modelReset();
        #1;
        chk("rst_vramEn", int'(vramEn), 0);
        chk("rst_vramWe", int'(vramWe), 0);
        chk("rst_full", int'(hostWrFull), 0);
        chk("rst_ovf", int'(hostWrOvf), 0);
        chk("rst_busy", int'(hostRdBusy), 0);
        chk("rst_rdValid", int'(hostRdValid), 0);
        chk("rst_dispValid", int'(dispValid), 0);
        chk("rst_rdData", int'(hostRdData), 0);
        repeat (2) tick();
        rst = 0;
        step(0, '0, 0, '0, '0, 0, '0);
    endtask

    initial begin
        port_t p;
        flag_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rsthold_vramEn", int'(vramEn), 0);
                chk("rsthold_vramWe", int'(vramWe), 0);
                chk("rsthold_rdValid", int'(hostRdValid), 0);
            end else if (portQ.size() == 0 || flagQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL expectation_queue actual empty required entry at %0t", $time);
            end else begin
                p = portQ.pop_front();
                f = flagQ.pop_front();
                chk("vramEn", int'(vramEn), int'(p.en));
                chk("vramWe", int'(vramWe), int'(p.we));
                if (p.en) chk("vramAddr", int'(vramAddr), int'(p.addr));
                if (p.we) chk("vramWrData", int'(vramWrData), int'(p.data));
                chk("hostWrFull", int'(hostWrFull), int'(f.full));
                chk("hostWrOvf", int'(hostWrOvf), int'(f.ovf));
                chk("hostRdBusy", int'(hostRdBusy), int'(f.busy));
                chk("dispValid", int'(dispValid), int'(f.dv));
                chk("hostRdValid", int'(hostRdValid), int'(f.rv));
                if (dispValid) begin
                    if (dispQ.size() > 0) chk("dispData", int'(dispData), int'(dispQ.pop_front()));
                    else begin
                        checks++; errors++;
                        $display("FAIL dispData actual unexpected_valid required none at %0t", $time);
                    end
                end
                if (hostRdValid) begin
                    if (rdQ.size() > 0) chk("hostRdData", int'(hostRdData), int'(rdQ.pop_front()));
                    else begin
                        checks++; errors++;
                        $display("FAIL hostRdData actual unexpected_valid required none at %0t", $time);
                    end
                end
            end
        end
    end

    initial begin
        int burst;
        bit d;
        for (int i = 0; i < (1 << AW); i++) begin
            vmem[i] = DW'(i);
            mMem[i] = DW'(i);
        end
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        step(0, '0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            step(1, AW'(i), 0, '0, '0, 0, '0);
        end
        idle(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            step(0, '0, 1, 13'h0123, 8'hA5, 0, '0);
        end
        idle(3);
        for (int i = 0; i < 10; i++) begin
            tick();
            step(1, AW'(i), i % 2 == 0, AW'(13'h40 + i), DW'(8'h80 + i), 0, '0);
        end
        idle(8);
        tick();
        step(0, '0, 1, 13'h1FFF, 8'h3C, 1, 13'h1FFF);
        idle(6);
        tick();
        step(1, 13'h5, 0, '0, '0, 1, 13'h0123);
        for (int i = 0; i < 9; i++) begin
            tick();
            step(1, AW'(i), 0, '0, '0, i >= 3, 13'h0040);
        end
        idle(5);
        tick();
        step(1, '0, 1, 13'h0010, 8'h55, 1, 13'h0010);
        tick();
        step(1, '0, 0, '0, '0, 0, '0);
        tick();
        step(1, '0, 1, 13'h0011, 8'h66, 0, '0);
        tick();
        doReset();
        idle(5);
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 499) == 0) doReset();
            else begin
                if (burst == 0)
                    burst = ($urandom_range(0, 3) == 0) ? -int'($urandom_range(1, 6))
                                                         : int'($urandom_range(1, 12));
                d = burst > 0;
                burst = burst > 0 ? burst - 1 : burst + 1;
                step(d, AW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
                     DW'($urandom), $urandom_range(0, 5) == 0, AW'($urandom_range(0, 15)));
            end
        end
        idle(12);
        chk("dispQ_drained", dispQ.size(), 0);
        chk("rdQ_drained", rdQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
